// File: rtl/sort_result_collector.sv
// sort_result_collector: consumes one frame of N signed words from the sorter
// stream and reports the frame's order check, min, max, median and sum.
// No element storage is used. Running values are kept internally, and the
// visible results are reloaded only when a frame completes.
module sort_result_collector #(
  parameter int N      = 10,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(N),
  parameter int SUM_W  = DATA_W + $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] data_serial_i,
  input  logic                     data_valid_i,
  output logic                     done_o,
  output logic                     sorted_ok_o,
  output logic [IDX_W-1:0]         err_idx_o,
  output logic signed [DATA_W-1:0] min_o,
  output logic signed [DATA_W-1:0] max_o,
  output logic signed [DATA_W-1:0] median_o,
  output logic signed [SUM_W-1:0]  sum_o,
  output logic [IDX_W:0]           count_o
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] MID_HI   = IDX_W'(N / 2);
  localparam logic [IDX_W-1:0] MID_LO   = IDX_W'(N / 2 - 1);
  localparam bit               N_EVEN   = (N % 2) == 0;

  state_t                   state_q, state_d;
  logic [IDX_W:0]           count_q, count_d;
  logic signed [DATA_W-1:0] min_q, min_d, max_q, max_d;
  logic signed [DATA_W-1:0] prev_q, prev_d, mlo_q, mlo_d, med_q, med_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic                     ok_q, ok_d;
  logic [IDX_W-1:0]         err_q, err_d;

  // Published results, held across the next frame until it completes
  logic                     done_q, done_d;
  logic signed [DATA_W-1:0] rmin_q, rmin_d, rmax_q, rmax_d, rmed_q, rmed_d;
  logic signed [SUM_W-1:0]  rsum_q, rsum_d;

  logic                     first;
  logic [IDX_W-1:0]         idx;
  logic signed [SUM_W-1:0]  w_ext;
  logic signed [DATA_W:0]   mpair;

  // Arrival index of the incoming word, and the widened forms used by the datapath
  always_comb begin
    first = (state_q != COLLECT);
    idx   = first ? '0 : count_q[IDX_W-1:0];
    w_ext = {{(SUM_W-DATA_W){data_serial_i[DATA_W-1]}}, data_serial_i};
    // The pair is summed one bit wider, so taking bits [DATA_W:1] is an
    // arithmetic shift that rounds toward -inf.
    mpair = {mlo_q[DATA_W-1], mlo_q} + {data_serial_i[DATA_W-1], data_serial_i};
  end

  // Next-state logic: accumulate on each valid word, and publish on the last one
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    min_d   = min_q;
    max_d   = max_q;
    sum_d   = sum_q;
    prev_d  = prev_q;
    mlo_d   = mlo_q;
    med_d   = med_q;
    ok_d    = ok_q;
    err_d   = err_q;
    done_d  = done_q;
    rmin_d  = rmin_q;
    rmax_d  = rmax_q;
    rmed_d  = rmed_q;
    rsum_d  = rsum_q;
    if (data_valid_i) begin
      if (first) begin
        min_d   = data_serial_i;
        max_d   = data_serial_i;
        sum_d   = w_ext;
        count_d = (IDX_W+1)'(1);
        ok_d    = 1'b1;
        err_d   = '0;
        done_d  = 1'b0;
        state_d = COLLECT;
      end else begin
        sum_d   = sum_q + w_ext;
        if (data_serial_i < min_q) min_d = data_serial_i;
        if (data_serial_i > max_q) max_d = data_serial_i;
        if (data_serial_i < prev_q && ok_q) begin
          ok_d  = 1'b0;
          err_d = idx;
        end
        count_d = count_q + 1'b1;
      end
      prev_d = data_serial_i;
      if (N_EVEN) begin
        if (idx == MID_LO) mlo_d = data_serial_i;
        if (idx == MID_HI) med_d = mpair[DATA_W:1];
      end else begin
        if (idx == MID_HI) med_d = data_serial_i;
      end
      if (idx == LAST_IDX) begin
        state_d = DONE;
        done_d  = 1'b1;
        rmin_d  = min_d;
        rmax_d  = max_d;
        rmed_d  = med_d;
        rsum_d  = sum_d;
      end
    end
  end

  // State and accumulator registers; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      min_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
      prev_q  <= '0;
      mlo_q   <= '0;
      med_q   <= '0;
      ok_q    <= 1'b1;
      err_q   <= '0;
      done_q  <= 1'b0;
      rmin_q  <= '0;
      rmax_q  <= '0;
      rmed_q  <= '0;
      rsum_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      min_q   <= min_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      prev_q  <= prev_d;
      mlo_q   <= mlo_d;
      med_q   <= med_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rmin_q  <= rmin_d;
      rmax_q  <= rmax_d;
      rmed_q  <= rmed_d;
      rsum_q  <= rsum_d;
    end
  end

  assign done_o      = done_q;
  assign sorted_ok_o = ok_q;
  assign err_idx_o   = err_q;
  assign min_o       = rmin_q;
  assign max_o       = rmax_q;
  assign median_o    = rmed_q;
  assign sum_o       = rsum_q;
  assign count_o     = count_q;

endmodule

// File: doc/sort_result_collector.md
Name: sort_result_collector

Overview:
- Downstream consumer of the BubbleSort serial output stream.
- Captures one frame of N signed words presented on data_serial/data_valid and checks that the frame is non-decreasing.
- Produces frame statistics for the sort benches and the system status path: min, max, median, sum, and the index of the first order violation.
- Streams on the fly; no element array is stored.

Parameters:
- N, 10, words per frame (N >= 2).
- DATA_W, 32, signed word width.
- IDX_W, $clog2(N), width of index and counter fields.
- SUM_W, DATA_W+$clog2(N), signed accumulator width; cannot overflow for N words.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- data_serial_i  in  DATA_W  signed word from the sorter (data_serial_o).
- data_valid_i  in  1  word valid; connects to the sorter's data_valid_o.
- done_o  out  1  frame complete; all result outputs are valid while high.
- sorted_ok_o  out  1  1 = every word i satisfies w[i] >= w[i-1] (signed).
- err_idx_o  out  IDX_W  index of the first word with w[i] < w[i-1]; 0 when sorted_ok_o=1.
- min_o  out  DATA_W  signed minimum of the frame.
- max_o  out  DATA_W  signed maximum of the frame.
- median_o  out  DATA_W  signed median of the frame in arrival order.
- sum_o  out  SUM_W  signed sum of the frame.
- count_o  out  IDX_W+1  words captured in the current frame.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: all outputs 0, except sorted_ok_o=1. State = IDLE.
- Reset mid-frame: discards all partial accumulation. The next valid word is treated as word 0.
- Capture rule: a word is captured on a posedge where data_valid_i=1. data_valid_i low means pause; gaps of any length are allowed, and state and accumulators hold.
- State IDLE:
  - On valid: min=max=w, sum=sext(w), prev=w, count=1.
  - sorted_ok=1, err_idx=0. Go to COLLECT.
- State COLLECT, on each valid word w at index i=count:
  - sum += sext(w).
  - min/max are updated by signed compare.
  - If w < prev (signed) and sorted_ok=1: sorted_ok=0, err_idx=i. Later violations do not change err_idx.
  - prev=w, count+1.
- Median capture:
  - N even: word N/2-1 is latched to mlo. When word N/2 arrives, median = (sext(mlo)+sext(w)) >>> 1, computed at DATA_W+1 bits, i.e. floor toward -inf.
  - N odd: median = word N/2.
- Frame completion:
  - When the captured word has index N-1, go to DONE.
  - done_o=1 and all results are registered and visible right after that same edge; there is no extra cycle of latency.
- State DONE:
  - Results and done_o hold until the next valid word.
  - That word starts a new frame exactly as in IDLE, and done_o=0 right after that edge.
  - Result outputs from the previous frame stay held until the new frame completes. sorted_ok_o/err_idx_o update live.
- Sign handling: all compares are signed. sext = sign-extension to SUM_W.
- Non-conforming upstream: if data_valid_i never reaches N words, done_o stays 0 indefinitely. There is no timeout.

Test Plan:
1. Reset, then send frame -881,-750,-347,-281,0,203,345,383,570,797 on consecutive cycles -> done_o=1 right after the 10th edge; sorted_ok_o=1, err_idx_o=0, min_o=-881, max_o=797, median_o=101, sum_o=39, count_o=10.
2. Send frame -750,-881,-347,-281,0,203,345,383,570,797 -> sorted_ok_o=0, err_idx_o=1, min_o=-881, max_o=797, sum_o=39.
3. Send frame -9,-8,-7,-6,-3,-2,1,2,3,4 -> median_o=-3 (floor of -2.5), sum_o=-25, sorted_ok_o=1.
4. Repeat scenario 1 with data_valid_i low for 3 cycles after words 2 and 7 -> identical results; done_o rises only after the 10th valid word.
5. Send 4 words 100,200,300,400, assert rst for 1 cycle, then send the scenario 1 frame -> results exactly as scenario 1; done_o stays 0 before the 10th word.
6. Send the scenario 1 frame immediately followed by ten words of 0x7FFFFFFF -> done_o drops for 9 cycles, then rises with sum_o=21474836470, median_o=2147483647, sorted_ok_o=1.
